// File: rtl/reg_writeback.sv
// reg_writeback: register-file writeback stage of the single-cycle RISC-V core.
//
// Takes a retiring instruction with its ALU result and writes either the ALU
// result or the extended load data to the register file. Loads wait in
// WAIT_MEM for a data-memory response, and the core is stalled while they
// wait. Writes to x0 and writes from non-writing opcodes are suppressed.
//
// Optional feature: define WB_RETIRE_CNT_EN to add the retired_cnt output.
//
// Parameters:
//   MEM_TIMEOUT  maximum cycles spent in WAIT_MEM before a load is abandoned (1..255)
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   wb_valid     retire request, accepted when wb_ready=1
//   instruction  retiring instruction: opcode [6:0], rd [11:7], funct3 [14:12]
//   alu_result   ALU output; the effective address for loads
//   mem_rdata    word-aligned data-memory read word
//   mem_rvalid   mem_rdata is valid this cycle
//   wb_ready     unit can accept (state IDLE)
//   stall        ~wb_ready
//   reg_write    registered register-file write enable
//   rd           registered destination register
//   write_data   registered write value
//   load_err     one-cycle pulse on a misaligned load or a timeout
//   retired_cnt  (WB_RETIRE_CNT_EN only) count of accepted instructions
//   fsm_state    debug view of the FSM: 0 = IDLE, 1 = WAIT_MEM
//
// Handshake: an instruction transfers on a rising edge where wb_valid=1 and
// wb_ready=1. While wb_ready=0 the core holds the instruction and its inputs
// stable. mem_rvalid is taken only in WAIT_MEM and is ignored in IDLE.
module reg_writeback #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] instruction,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        wb_ready,
    output logic        stall,
    output logic        reg_write,
    output logic [4:0]  rd,
    output logic [31:0] write_data,
    output logic        load_err,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0] retired_cnt,
`endif
    output logic        fsm_state
);

    typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_lane;
    logic        latch_load;
    logic        wr_en, err_next;
    logic [31:0] wr_data;
    logic [4:0]  wr_rd;

    logic [6:0]  opcode;
    logic [4:0]  instr_rd;
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic        accept;
    logic [7:0]  cnt_inc;
    logic        unused_bits;

    assign opcode      = instruction[6:0];
    assign instr_rd    = instruction[11:7];
    assign funct3      = instruction[14:12];
    assign lane        = alu_result[1:0];
    assign unused_bits = ^instruction[31:15];

    assign wb_ready  = (state == IDLE);
    assign stall     = ~wb_ready;
    assign accept    = wb_valid && wb_ready;
    assign cnt_inc   = cnt + 8'd1;
    assign fsm_state = state;

    // Halfword loads need lane[0]=0. Word loads, including the reserved
    // funct3 codes that are treated as LW, need lane=0.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] ln);
        case (f3)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = ln[0];
            default:        misaligned = (ln != 2'b00);
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] ln,
                                           input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*ln +: 8];
        h = ln[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extend = {{24{b[7]}}, b};
            3'b100:  extend = {24'd0, b};
            3'b001:  extend = {{16{h[15]}}, h};
            3'b101:  extend = {16'd0, h};
            default: extend = word;
        endcase
    endfunction

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        latch_load = 1'b0;
        wr_en      = 1'b0;
        wr_rd      = instr_rd;
        wr_data    = alu_result;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (opcode == OP_R || opcode == OP_I) begin
                        wr_en = (instr_rd != 5'd0);
                    end else if (opcode == OP_LOAD) begin
                        if (misaligned(funct3, lane)) begin
                            err_next = 1'b1;
                        end else begin
                            state_next = WAIT_MEM;
                            cnt_next   = 8'd0;
                            latch_load = 1'b1;
                        end
                    end
                end
            end
            WAIT_MEM: begin
                wr_rd   = ld_rd;
                wr_data = extend(ld_funct3, ld_lane, mem_rdata);
                // A response in the same cycle as the timeout still wins.
                if (mem_rvalid) begin
                    wr_en      = (ld_rd != 5'd0);
                    state_next = IDLE;
                end else if (cnt_inc == TIMEOUT) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            ld_rd      <= 5'd0;
            ld_funct3  <= 3'd0;
            ld_lane    <= 2'd0;
            reg_write  <= 1'b0;
            rd         <= 5'd0;
            write_data <= 32'd0;
            load_err   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            reg_write <= wr_en;
            load_err  <= err_next;
            if (latch_load) begin
                ld_rd     <= instr_rd;
                ld_funct3 <= funct3;
                ld_lane   <= lane;
            end
            if (wr_en) begin
                rd         <= wr_rd;
                write_data <= wr_data;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_cnt <= 32'd0;
        end else if (accept) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Testbench for reg_writeback: directed cases followed by a randomized
// sequence, all checked against a behavioural model of the writeback rules.
module tb_reg_writeback;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [31:0] instruction;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        wb_ready;
    logic        stall;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic        load_err;
    logic        fsm_state;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retired_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int model_retired = 0;
    logic [36:0] exp_q[$];

    reg_writeback #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .instruction(instruction),
        .alu_result(alu_result), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .wb_ready(wb_ready), .stall(stall), .reg_write(reg_write), .rd(rd),
        .write_data(write_data), .load_err(load_err),
`ifdef WB_RETIRE_CNT_EN
        .retired_cnt(retired_cnt),
`endif
        .fsm_state(fsm_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] r, input logic [2:0] f3);
        mk = {17'd0, f3, r, op};
        mk[31:15] = 17'(($urandom & 32'h1FFFF));
    endfunction

    // Reference: loaded value from word, funct3 and byte offset.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] word);
        logic [31:0] v;
        case (f3)
            3'b000, 3'b100: begin
                v = (word >> (8 * off)) % 256;
                if (f3 == 3'b000 && v >= 128) v = v + 32'hFFFFFF00;
            end
            3'b001, 3'b101: begin
                v = (word >> (16 * (off / 2))) % 65536;
                if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF0000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic int access_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    // Compare the write port against the model for the current cycle.
    task automatic check_write(input string tag, input bit exp_wr);
        logic [36:0] e;
        chk({tag, "_reg_write"}, 32'(reg_write), 32'(exp_wr));
        if (exp_wr && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_rd"}, 32'(rd), 32'(e[36:32]));
            chk({tag, "_data"}, write_data, e[31:0]);
        end
    endtask

    // Driver + model: retire one instruction; loads get their response
    // `delay` cycles after acceptance (never if delay > T).
    task automatic do_op(input string tag, input logic [6:0] op, input logic [4:0] r,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input int delay, input logic [31:0] rdata);
        int  off;
        bit  done;
        instruction = mk(op, r, f3);
        alu_result  = alu;
        wb_valid    = 1'b1;
        chk({tag, "_ready_at_accept"}, 32'(wb_ready), 32'd1);
        model_retired++;
        step();
        wb_valid = 1'b0;
        off = int'(alu % 4);
        if (op == 7'b0000011) begin
            if (off % access_size(f3) != 0) begin
                chk({tag, "_misalign_err"}, 32'(load_err), 32'd1);
                check_write(tag, 1'b0);
                chk({tag, "_misalign_stall"}, 32'(stall), 32'd0);
                return;
            end
            done = 1'b0;
            for (int c = 1; c <= T && !done; c++) begin
                chk({tag, "_wait_stall"}, 32'(stall), 32'd1);
                chk({tag, "_wait_wr"}, 32'(reg_write), 32'd0);
                if (c == delay) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rdata;
                    step();
                    mem_rvalid = 1'b0;
                    mem_rdata  = $urandom;
                    if (r != 0) exp_q.push_back({r, model_load(f3, off, rdata)});
                    check_write(tag, r != 0);
                    chk({tag, "_load_ready"}, 32'(wb_ready), 32'd1);
                    chk({tag, "_load_err"}, 32'(load_err), 32'd0);
                    done = 1'b1;
                end else begin
                    step();
                end
            end
            if (!done) begin
                chk({tag, "_timeout_err"}, 32'(load_err), 32'd1);
                check_write(tag, 1'b0);
                chk({tag, "_timeout_ready"}, 32'(wb_ready), 32'd1);
            end
        end else begin
            if ((op == 7'b0110011 || op == 7'b0010011) && r != 0) begin
                exp_q.push_back({r, alu});
                check_write(tag, 1'b1);
            end else begin
                check_write(tag, 1'b0);
            end
            chk({tag, "_alu_ready"}, 32'(wb_ready), 32'd1);
            chk({tag, "_alu_err"}, 32'(load_err), 32'd0);
        end
    endtask

    task automatic idle_check(input string tag);
        step();
        chk({tag, "_idle_wr"}, 32'(reg_write), 32'd0);
        chk({tag, "_idle_err"}, 32'(load_err), 32'd0);
        chk({tag, "_idle_ready"}, 32'(wb_ready), 32'd1);
    endtask

    initial begin
        logic [6:0] ops [6];
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1111111;

        // Reset
        reset = 1'b1; wb_valid = 1'b0; instruction = 32'd0; alu_result = 32'd0;
        mem_rdata = 32'd0; mem_rvalid = 1'b0;
        step();
        chk("rst_ready", 32'(wb_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        step();
        reset = 1'b0;
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_data", write_data, 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);

        // Directed cases
        do_op("add", 7'b0110011, 5'd5, 3'b000, 32'h0000_1234, 0, 0);
        idle_check("add_once");
        do_op("lb", 7'b0000011, 5'd7, 3'b000, 32'h0000_1003, 3, 32'h80FF_0000);
        do_op("lbu", 7'b0000011, 5'd7, 3'b100, 32'h0000_1003, 3, 32'h80FF_0000);
        do_op("lh", 7'b0000011, 5'd9, 3'b001, 32'h0000_2002, 1, 32'h9ABC_5678);
        do_op("lhu", 7'b0000011, 5'd9, 3'b101, 32'h0000_2002, 2, 32'h9ABC_5678);
        do_op("lw_mis", 7'b0000011, 5'd3, 3'b010, 32'h0000_0001, 0, 0);
        do_op("lh_mis", 7'b0000011, 5'd3, 3'b001, 32'h0000_0003, 0, 0);
        do_op("lw", 7'b0000011, 5'd4, 3'b010, 32'h0000_0100, T, 32'hCAFE_F00D);
        do_op("lw_tmo", 7'b0000011, 5'd4, 3'b010, 32'h0000_0100, T + 5, 0);
        // Stray response while idle
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        mem_rvalid = 1'b0;
        chk("stray_wr", 32'(reg_write), 32'd0);
        chk("stray_ready", 32'(wb_ready), 32'd1);
        do_op("sw", 7'b0100011, 5'd6, 3'b010, 32'h0000_0040, 0, 0);
        do_op("beq", 7'b1100011, 5'd6, 3'b000, 32'h0000_0040, 0, 0);
        do_op("addi_x0", 7'b0010011, 5'd0, 3'b000, 32'h0000_0077, 0, 0);
        do_op("lw_x0", 7'b0000011, 5'd0, 3'b010, 32'h0000_0200, 2, 32'h5555_AAAA);

        // Reset while waiting for memory
        instruction = mk(7'b0000011, 5'd8, 3'b010);
        alu_result = 32'h0000_0300; wb_valid = 1'b1;
        step();
        wb_valid = 1'b0;
        model_retired++;
        chk("mid_rst_stall", 32'(stall), 32'd1);
        reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        reset = 1'b0; mem_rvalid = 1'b0;
        model_retired = 0;
        chk("mid_rst_wr", 32'(reg_write), 32'd0);
        chk("mid_rst_rd", 32'(rd), 32'd0);
        chk("mid_rst_data", write_data, 32'd0);
        chk("mid_rst_err", 32'(load_err), 32'd0);
        chk("mid_rst_ready", 32'(wb_ready), 32'd1);
        idle_check("mid_rst_after");

        // Randomized sequence
        for (int i = 0; i < 60; i++) begin
            do_op("rand", ops[$urandom_range(0, 5)], 5'($urandom_range(0, 31)),
                  3'($urandom_range(0, 7)), $urandom, $urandom_range(1, T + 1), $urandom);
            if ($urandom_range(0, 3) == 0) idle_check("rand_gap");
        end

`ifdef WB_RETIRE_CNT_EN
        chk("retired_cnt", retired_cnt, 32'(model_retired));
`endif
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback unit driving the register-file write port (`reg_write`, `rd`, `write_data`) of the single-cycle RISC-V core. It accepts a retiring instruction and its ALU result, selects between the ALU result and load data, and sign- or zero-extends load data by `funct3` and byte lane. It waits a variable number of cycles for data-memory read responses, stalling the core meanwhile. It suppresses writes to x0 and for non-writing opcodes.

## Interface
- `MEM_TIMEOUT`, 15: maximum cycles spent in WAIT_MEM before the load is abandoned (1..255).
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `wb_valid` in 1: instruction retire request; accepted when `wb_ready`=1.
- `instruction` in 32: retiring instruction; opcode [6:0], rd [11:7], funct3 [14:12].
- `alu_result` in 32: ALU output; the effective address for loads.
- `mem_rdata` in 32: data-memory read word (word-aligned).
- `mem_rvalid` in 1: `mem_rdata` valid this cycle.
- `wb_ready` out 1: unit can accept (state IDLE).
- `stall` out 1: equals `~wb_ready`.
- `reg_write` out 1: register-file write enable, registered.
- `rd` out 5: destination register, registered.
- `write_data` out 32: write value, registered.
- `load_err` out 1: one-cycle pulse on a misaligned load or timeout.

## Operation
- States: IDLE, WAIT_MEM.
- Write classes:
  - Opcodes 0110011 (R) and 0010011 (I-arith) write `alu_result`.
  - Opcode 0000011 (load) writes extended memory data.
  - All other opcodes (S 0100011, SB 1100011, unknown) are accepted with no write.
- rd = 0: the instruction is accepted, but `reg_write` stays 0. A load to x0 still enters WAIT_MEM and consumes the response.
- Load extension, using lane = `alu_result[1:0]`:
  - funct3 000 LB: sign-extend byte[lane].
  - funct3 100 LBU: zero-extend byte[lane].
  - funct3 001 LH: sign-extend half[lane[1]].
  - funct3 101 LHU: zero-extend half[lane[1]].
  - funct3 010 LW: full word.
  - Any other funct3 is treated as LW.
- Misaligned load: LH/LHU with lane[0]=1, or LW with lane≠0.
  - `load_err` pulses, no write occurs, and the state stays IDLE.
- IDLE → WAIT_MEM: an aligned load is accepted. The unit latches rd, funct3, and lane, and clears the timeout counter.
- WAIT_MEM → IDLE: on `mem_rvalid`=1, the unit writes the extended data.
- WAIT_MEM → IDLE on timeout: the counter reaches `MEM_TIMEOUT` without `mem_rvalid`. `load_err` pulses and no write occurs.
- `mem_rvalid` while in IDLE is ignored.
- `wb_valid` while in WAIT_MEM is not accepted. The core holds the instruction and its inputs stable.

## Timing
- Reset values: state IDLE, `reg_write`=0, `rd`=0, `write_data`=0, `load_err`=0, counter 0. As a result, `wb_ready`=1 and `stall`=0 during and after reset.
- ALU writeback: accepted in cycle N; `reg_write`=1 with data in cycle N+1, for exactly one cycle.
- Load writeback: `mem_rvalid` in cycle M (in WAIT_MEM); `reg_write`=1 in cycle M+1. `wb_ready` returns to 1 in M+1, so a new instruction can be accepted in M+1.
- `mem_rvalid` can arrive at the earliest in the cycle after acceptance.
- The timeout counter increments once per WAIT_MEM cycle. The abort occurs on the cycle where count = `MEM_TIMEOUT`; `load_err` is high in the following cycle.
- If `mem_rvalid` and timeout occur in the same cycle, `mem_rvalid` wins and the write happens.
- Reset asserted in WAIT_MEM: the unit returns to IDLE next cycle, and the pending load is dropped without a write.
- Write outputs are plain registers; `reg_write` is 0 in every cycle that does not carry a write.

## Configuration
- `WB_RETIRE_CNT_EN`:
  - Defined: adds output `retired_cnt` (32 bits). It resets to 0 and increments by 1 for each accepted instruction, including non-writing and misaligned ones. Loads count at acceptance, timeouts included. It wraps from 0xFFFFFFFF to 0.
  - Undefined: no port and no counter logic; all other behaviour is identical.

## Test plan
- ADD with rd=5, `alu_result`=0x1234 → `reg_write`=1, rd=5, data 0x1234 one cycle later; `wb_ready` stays 1.
- LB with rd=7, addr 0x...03, `mem_rdata`=0x80FF0000 after 3 cycles → `stall`=1 for 3 cycles, then writes 0xFFFFFF80. Same case with LBU → 0x00000080.
- LH with addr 0x...02, `mem_rdata`=0x9ABC5678 → 0xFFFF9ABC. LW with addr 0x...01 → `load_err` pulse, no write, `stall` stays 0.
- LW with `MEM_TIMEOUT`=4 and no `mem_rvalid` → `load_err` pulse 5 cycles after acceptance, no write, return to IDLE. A stray `mem_rvalid` in IDLE is ignored.
- SW, BEQ, and ADDI with rd=0 → no `reg_write`. Reset asserted mid-WAIT_MEM → no write, all outputs 0, `wb_ready`=1.
- With `WB_RETIRE_CNT_EN`: 10 mixed instructions → `retired_cnt`=10. Preload 0xFFFFFFFF, then one retire → 0.
